muldiv_ctrl: RTL

Multi-cycle multiply/divide unit and scheduler beside the EX-stage ALU. It owns the HI/LO registers, sequences mult/multu/div/divu over a fixed latency, and applies mthi/mtlo writes. It drives busy and a stall request so the hazard unit can freeze the D stage while the resource is occupied.

---
 rtl/muldiv_ctrl_pkg.sv | 28 ++
 rtl/muldiv_ctrl_if.sv | 24 ++
 rtl/muldiv_ctrl_md_arith.sv | 47 ++++
 rtl/muldiv_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states,
// default latencies and the opcode classifier used by the stall logic.
package muldiv_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   localparam int unsigned MD_MULT_LAT_DEF = 5;
   localparam int unsigned MD_DIV_LAT_DEF  = 10;
   localparam int unsigned MD_CNT_W        = 4;

   function automatic logic md_is_arith(logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage handshake between the pipeline and the multiply/divide unit,
// including the HI/LO read path and the hazard-unit stall request.
interface muldiv_ctrl_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   logic        md_use_D;
   logic        busy;
   logic        stall_req;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start, op, A, B, flush, md_use_D,
      input  busy, stall_req, HI, LO
   );

   modport slave (
      input  start, op, A, B, flush, md_use_D,
      output busy, stall_req, HI, LO
   );
endinterface

// File: rtl/muldiv_ctrl_md_arith.sv
// Combinational multiply/divide datapath producing the pending {HI, LO}
// pair and a divide-by-zero flag from the EX operands.
module muldiv_ctrl_md_arith
   import muldiv_ctrl_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] p_hi_o,
   output logic [31:0] p_lo_o,
   output logic        div0_o
);

   logic        sx_mul;
   logic        neg_a;
   logic        neg_b;
   logic [63:0] prod;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] qm;
   logic [31:0] rm;

   // One unsigned multiplier/divider serves both signednesses: the multiply
   // sign-extends, the divide works on magnitudes and re-applies the signs.
   always_comb begin
      sx_mul = (op_i == MD_MULT);
      neg_a  = (op_i == MD_DIV) & a_i[31];
      neg_b  = (op_i == MD_DIV) & b_i[31];
      prod   = {{32{sx_mul & a_i[31]}}, a_i} * {{32{sx_mul & b_i[31]}}, b_i};
      mag_a  = neg_a ? -a_i : a_i;
      mag_b  = (b_i == '0) ? 32'd1 : (neg_b ? -b_i : b_i);
      qm     = mag_a / mag_b;
      rm     = mag_a % mag_b;
      div0_o = (b_i == '0) & ((op_i == MD_DIV) | (op_i == MD_DIVU));
      p_hi_o = '0;
      p_lo_o = '0;
      case (op_i)
         MD_MULT, MD_MULTU: {p_hi_o, p_lo_o} = prod;
         MD_DIV, MD_DIVU: begin
            p_lo_o = (neg_a ^ neg_b) ? -qm : qm;
            p_hi_o = neg_a ? -rm : rm;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide scheduler owning HI/LO; holds busy for a fixed
// latency per operation and raises a stall request for dependent D-stage ops.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = MD_MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = MD_DIV_LAT_DEF
) (
   input  logic          clk,
   input  logic          reset,
   muldiv_ctrl_if.slave  md
);

   localparam logic [MD_CNT_W-1:0] MULT_CNT = MD_CNT_W'(MULT_LAT - 1);
   localparam logic [MD_CNT_W-1:0] DIV_CNT  = MD_CNT_W'(DIV_LAT - 1);

   md_state_e           state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]         hi_q, hi_d;
   logic [31:0]         lo_q, lo_d;
   logic [31:0]         p_hi_q, p_hi_d;
   logic [31:0]         p_lo_q, p_lo_d;
   logic                div0_q, div0_d;
   logic [31:0]         ar_hi;
   logic [31:0]         ar_lo;
   logic                ar_div0;

   muldiv_ctrl_md_arith u_arith (
      .op_i   (md.op),
      .a_i    (md.A),
      .b_i    (md.B),
      .p_hi_o (ar_hi),
      .p_lo_o (ar_lo),
      .div0_o (ar_div0)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         p_hi_q  <= '0;
         p_lo_q  <= '0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         p_hi_q  <= p_hi_d;
         p_lo_q  <= p_lo_d;
         div0_q  <= div0_d;
      end
   end

   // The result is computed at issue; BUSY only models the unit's latency.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      p_hi_d  = p_hi_q;
      p_lo_d  = p_lo_q;
      div0_d  = div0_q;
      if (md.flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (md.start) begin
                  case (md.op)
                     MD_MULT, MD_MULTU: begin
                        state_d = ST_BUSY;
                        cnt_d   = MULT_CNT;
                        p_hi_d  = ar_hi;
                        p_lo_d  = ar_lo;
                        div0_d  = 1'b0;
                     end
                     MD_DIV, MD_DIVU: begin
                        state_d = ST_BUSY;
                        cnt_d   = DIV_CNT;
                        p_hi_d  = ar_hi;
                        p_lo_d  = ar_lo;
                        div0_d  = ar_div0;
                     end
                     MD_MTHI: hi_d = md.A;
                     MD_MTLO: lo_d = md.A;
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
                  if (!div0_q) begin
                     hi_d = p_hi_q;
                     lo_d = p_lo_q;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign md.busy      = (state_q == ST_BUSY);
   assign md.stall_req = md.md_use_D & (md.busy | (md.start & md_is_arith(md.op)));
   assign md.HI        = hi_q;
   assign md.LO        = lo_q;

endmodule
